board_engine: RTL and testbench
===============================

# board_engine

Connect-4 board store and move evaluator sitting directly upstream of the game FSM. Accepts a column drop from the current player and places the piece in the lowest free row. It then scans the four line directions through that piece and reports a full/out-of-range column (`invalid_column`) or the resulting game status, which feeds the FSM's `invalid_column` and `in_game_status` inputs. A combinational read port exposes any cell to the display path.

## Interface
- `COLS`, 7: board columns; the bench targets the default.
- `ROWS`, 6: board rows; row 0 is the bottom.
- `WIN_LEN`, 4: contiguous pieces required to win.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `drop_valid`  in  1  move request, sampled in IDLE only.
- `drop_col`  in  3  target column, 0..COLS-1.
- `player`  in  1  mover: 0 = P1, 1 = P2; sampled with `drop_valid`.
- `rd_row`  in  3  display read row.
- `rd_col`  in  3  display read column.
- `rd_cell`  out  2  combinational cell contents: 00 empty, 01 P1, 10 P2; out-of-range address returns 00.
- `busy`  out  1  high while a move is being processed.
- `done`  out  1  one-cycle pulse; move processing finished.
- `invalid_column`  out  1  one-cycle pulse, coincident with `done`; move rejected.
- `game_status`  out  2  00 playing, 01 win by the last mover, 10 tie (board full); 11 never driven; held.

## Operation
- State: 42 cells × 2 bits; per-column height counters 0..ROWS; a move counter 0..42.
- State machine: IDLE, PLACE, CHK_H, CHK_V, CHK_D1 (up-right), CHK_D2 (up-left).
- IDLE: if `drop_valid`=1 and `game_status`=00, latch `drop_col` and `player`, go to PLACE. Otherwise stay in IDLE.
- PLACE, rejection path: taken if `drop_col` ≥ COLS or that column's height = ROWS.
  - Pulse `invalid_column` and `done`, return to IDLE.
  - Board, heights, move counter and `game_status` are unchanged.
- PLACE, normal path:
  - Write the mover's code at (height, col).
  - Latch the placed row.
  - Increment the column height and the move counter.
  - Go to CHK_H.
- Each CHK state evaluates one direction (dr,dc) ∈ {(0,1),(1,0),(1,1),(1,-1)}.
  - Count contiguous same-player cells from the placed piece: up to WIN_LEN-1 cells forward and up to WIN_LEN-1 cells backward, plus 1.
  - Stop at a board edge or at a non-matching cell.
  - OR the result (count ≥ WIN_LEN) into a sticky win flag.
- Exit from CHK_D2:
  - `game_status` ← 01 if the win flag is set.
  - Else `game_status` ← 10 if the move counter = 42.
  - Else `game_status` stays 00.
  - Pulse `done`, clear the win flag, return to IDLE.
- A win on the 42nd move reports 01, not 10.
- Once `game_status` ≠ 00, all drops are ignored: no `done`, no `invalid_column`, board frozen until reset.
- `drop_valid` while `busy`=1 is ignored; it is not queued.

## Timing
- Reset (`reset`=0 at an edge) produces all of the following at that edge:
  - board all 00, heights 0, move counter 0;
  - state IDLE;
  - `busy`=0, `done`=0, `invalid_column`=0, `game_status`=00.
- Reset mid-move aborts the move with no `done`. Reset has priority over all other inputs.
- Let E0 be the edge that samples a drop.
- `busy` is high from after E0 until the cycle in which `done` is high, inclusive.
- Rejected move: `invalid_column`=1 and `done`=1 in the cycle after E1 (latency 2); `busy` falls after E2.
- Accepted move:
  - the placed cell is visible on `rd_cell` after E1;
  - `done`=1 and the new `game_status` are visible after E5 (latency 6);
  - `busy` falls after E6.
- The next drop can be sampled at the edge ending the `done` cycle.
- All outputs except `rd_cell` are registered.

## Test plan
- Reset, then P1 drops col 3 → after 6 cycles `done`=1, `invalid_column`=0, `game_status`=00, `rd_cell`(0,3)=01.
- Six alternating drops into col 0, then a 7th → 7th gives `invalid_column`=1 and `done`=1 at latency 2; heights and board unchanged; `drop_col`=7 behaves the same.
- P1 at cols 0,1,2,3 row 0 (P2 stacking on col 6) → the 4th P1 move gives `game_status`=01; further `drop_valid` produces no `done`.
- Vertical win in col 4, then diagonal wins up-right and up-left built with filler pieces → `game_status`=01 in each case.
- Fill all 42 cells in a no-win pattern → the 42nd `done` shows `game_status`=10.
- Assert `reset`=0 during CHK_V → no `done`; after reset all `rd_cell`=00 and `game_status`=00; `drop_valid` during `busy` is ignored.

Source files
------------

// File: rtl/board_engine.sv
// board_engine: Connect-4 board store that places a dropped piece and scans the four line directions through it
module board_engine #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  input  logic       player,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell,
  output logic       busy,
  output logic       done,
  output logic       invalid_column,
  output logic [1:0] game_status
);
  localparam int CELLS = ROWS * COLS;
  localparam int IW = $clog2(CELLS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(CELLS + 1);
  localparam logic [2:0] IDLE = 3'd0, PLACE = 3'd1, CHK_H = 3'd2, CHK_V = 3'd3, CHK_D1 = 3'd4, CHK_D2 = 3'd5;

  logic [CELLS-1:0][1:0] board_q, board_d;
  logic [COLS-1:0][HW-1:0] height_q, height_d;
  logic [MW-1:0] moves_q, moves_d;
  logic [2:0] state_q, state_d, col_q, col_d;
  logic [HW-1:0] row_q, row_d, col_h;
  logic player_q, player_d, win_q, win_d, busy_q, busy_d, done_q, done_d, inv_q, inv_d;
  logic [1:0] status_q, status_d, code;
  logic col_full, hit, fwd, bwd;
  int dr, dc, cnt;

  function automatic logic [1:0] cell_at(input logic [CELLS-1:0][1:0] b, input int r, input int c);
    return (r >= 0 && r < ROWS && c >= 0 && c < COLS) ? b[IW'(r * COLS + c)] : 2'b00;
  endfunction

  assign rd_cell = cell_at(board_q, int'(rd_row), int'(rd_col));
  assign busy = busy_q;
  assign done = done_q;
  assign invalid_column = inv_q;
  assign game_status = status_q;

  always_comb begin
    code = player_q ? 2'b10 : 2'b01;
    col_h = (int'(col_q) < COLS) ? height_q[col_q] : HW'(ROWS);
    col_full = int'(col_h) == ROWS;
    dr = (state_q == CHK_H) ? 0 : 1;
    dc = (state_q == CHK_V) ? 0 : (state_q == CHK_D2) ? -1 : 1;
    cnt = 1;
    fwd = 1'b1;
    bwd = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      fwd = fwd && cell_at(board_q, int'(row_q) + k * dr, int'(col_q) + k * dc) == code;
      bwd = bwd && cell_at(board_q, int'(row_q) - k * dr, int'(col_q) - k * dc) == code;
      cnt = cnt + int'(fwd) + int'(bwd);
    end
    hit = cnt >= WIN_LEN;
  end

  always_comb begin
    board_d = board_q;
    height_d = height_q;
    moves_d = moves_q;
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    player_d = player_q;
    win_d = win_q;
    status_d = status_q;
    done_d = 1'b0;
    inv_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (drop_valid && status_q == 2'b00) begin
          col_d = drop_col;
          player_d = player;
          state_d = PLACE;
        end
      end
      PLACE: begin
        if (col_full) begin
          done_d = 1'b1;
          inv_d = 1'b1;
          state_d = IDLE;
        end else begin
          board_d[IW'(int'(col_h) * COLS + int'(col_q))] = code;
          row_d = col_h;
          height_d[col_q] = col_h + 1'b1;
          moves_d = moves_q + 1'b1;
          state_d = CHK_H;
        end
      end
      CHK_H, CHK_V, CHK_D1: begin
        win_d = win_q | hit;
        state_d = state_q + 3'd1;
      end
      CHK_D2: begin
        status_d = (win_q | hit) ? 2'b01 : (int'(moves_q) == CELLS) ? 2'b10 : 2'b00;
        done_d = 1'b1;
        win_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      board_q <= '0;
      height_q <= '0;
      moves_q <= '0;
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      player_q <= 1'b0;
      win_q <= 1'b0;
      status_q <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      board_q <= board_d;
      height_q <= height_d;
      moves_q <= moves_d;
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      player_q <= player_d;
      win_q <= win_d;
      status_q <= status_d;
      busy_q <= busy_d;
      done_q <= done_d;
      inv_q <= inv_d;
    end
  end
endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: table-driven and randomized checks of board_engine against a whole-board reference model
module tb_board_engine;
  localparam int COLS = 7;
  localparam int ROWS = 6;

  logic clk = 1'b0, reset = 1'b0, drop_valid = 1'b0, player = 1'b0;
  logic [2:0] drop_col = '0, rd_row = '0, rd_col = '0;
  logic [1:0] rd_cell, game_status;
  logic busy, done, invalid_column;

  board_engine dut (
    .clk(clk), .reset(reset), .drop_valid(drop_valid), .drop_col(drop_col), .player(player),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell), .busy(busy), .done(done),
    .invalid_column(invalid_column), .game_status(game_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int col;
    int pl;
    int inv;
    int st;
  } vec_t;
  vec_t tv[$];

  int checks = 0, failures = 0;
  int mb[ROWS][COLS];
  int mh[COLS];
  int mm, mst;
  int got_done, got_k, got_inv, got_st, got_busy0, got_busyd, got_busy_end, got_cell1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    for (int c = 0; c < COLS; c++) mh[c] = 0;
    mm = 0;
    mst = 0;
  endfunction

  function automatic bit has_win(input int p);
    int drs[4];
    int dcs[4];
    int run, rr, cc;
    drs = '{0, 1, 1, 1};
    dcs = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          run = 0;
          for (int k = 0; k < 4; k++) begin
            rr = r + k * drs[d];
            cc = c + k * dcs[d];
            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              if (mb[rr][cc] == p) run++;
          end
          if (run == 4) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic void model_drop(input int col, input int pl, output int inv, output int row);
    inv = 1;
    row = -1;
    if (col < COLS) begin
      if (mh[col] < ROWS) begin
        inv = 0;
        row = mh[col];
        mb[row][col] = pl + 1;
        mh[col]++;
        mm++;
        if (has_win(pl + 1)) mst = 1;
        else if (mm == ROWS * COLS) mst = 2;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drop_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_inv", int'(invalid_column), 0);
    chk("reset_status", int'(game_status), 0);
  endtask

  task automatic drop(input int col, input int pl);
    @(negedge clk);
    drop_col = 3'(col);
    player = pl[0];
    drop_valid = 1'b1;
    @(negedge clk);
    drop_valid = 1'b0;
    got_busy0 = int'(busy);
    got_done = 0;
    got_k = 0;
    got_cell1 = 0;
    for (int i = 1; i <= 12 && got_done == 0; i++) begin
      @(negedge clk);
      if (i == 1) got_cell1 = int'(rd_cell);
      if (done) begin
        got_done = 1;
        got_k = i;
        got_inv = int'(invalid_column);
        got_st = int'(game_status);
        got_busyd = int'(busy);
      end
    end
    @(negedge clk);
    got_busy_end = int'(busy);
  endtask

  task automatic apply(input string tag, input int col, input int pl, input int e_inv, input int e_st);
    int m_inv, m_row;
    model_drop(col, pl, m_inv, m_row);
    if (e_inv < 0) begin
      e_inv = m_inv;
      e_st = mst;
    end
    rd_row = (m_row >= 0) ? 3'(m_row) : 3'd0;
    rd_col = 3'(col);
    drop(col, pl);
    chk($sformatf("%s_done", tag), got_done, 1);
    chk($sformatf("%s_latency", tag), got_k, (e_inv != 0) ? 1 : 5);
    chk($sformatf("%s_inv", tag), got_inv, e_inv);
    chk($sformatf("%s_status", tag), got_st, e_st);
    chk($sformatf("%s_busy", tag), got_busy0 & got_busyd & (got_busy_end ^ 1), 1);
    if (m_row >= 0) chk($sformatf("%s_cell_after_e1", tag), got_cell1, pl + 1);
  endtask

  task automatic compare_board(input string tag);
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        if (int'(rd_cell) != mb[r][c]) bad++;
      end
    chk($sformatf("%s_board", tag), bad, 0);
    rd_row = 3'd6;
    rd_col = 3'd0;
    #1;
    chk($sformatf("%s_rd_row_oob", tag), int'(rd_cell), 0);
    rd_row = 3'd0;
    rd_col = 3'd7;
    #1;
    chk($sformatf("%s_rd_col_oob", tag), int'(rd_cell), 0);
  endtask

  task automatic check_ignored(input string tag);
    int seen = 0;
    @(negedge clk);
    drop_col = 3'd1;
    player = 1'b0;
    drop_valid = 1'b1;
    repeat (3) @(negedge clk);
    drop_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || invalid_column || busy) seen++;
    end
    chk($sformatf("%s_ignored", tag), seen, 0);
    chk($sformatf("%s_held_status", tag), int'(game_status), mst);
    compare_board($sformatf("%s_frozen", tag));
  endtask

  function automatic void add(input bit r, input int c, input int p, input int i, input int s);
    vec_t v;
    v.rst = r;
    v.col = c;
    v.pl = p;
    v.inv = i;
    v.st = s;
    tv.push_back(v);
  endfunction

  initial begin
    int dones, m_inv, m_row, n;
    add(1, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, (i + 1) % 2, 0, 0);
    add(0, 0, 1, 1, 0);
    add(0, 7, 1, 1, 0);
    add(1, 3, 0, 0, 0); add(0, 6, 1, 0, 0); add(0, 2, 0, 0, 0); add(0, 6, 1, 0, 0);
    add(0, 1, 0, 0, 0); add(0, 6, 1, 0, 0); add(0, 0, 0, 0, 1);
    add(1, 4, 0, 0, 0); add(0, 5, 1, 0, 0); add(0, 4, 0, 0, 0); add(0, 5, 1, 0, 0);
    add(0, 4, 0, 0, 0); add(0, 5, 1, 0, 0); add(0, 4, 0, 0, 1);
    add(1, 0, 0, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 0, 0, 0); add(0, 2, 1, 0, 0); add(0, 2, 1, 0, 0);
    add(0, 2, 0, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 0, 0, 1);
    add(1, 6, 0, 0, 0); add(0, 5, 1, 0, 0); add(0, 5, 0, 0, 0); add(0, 4, 1, 0, 0); add(0, 4, 1, 0, 0);
    add(0, 4, 0, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 0, 0, 1);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        add(c == 0 && r == 0, c, ((r / 2) + c) % 2, 0, (c == COLS - 1 && r == ROWS - 1) ? 2 : 0);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      apply($sformatf("vec%0d", i), tv[i].col, tv[i].pl, tv[i].inv, tv[i].st);
      if (i == tv.size() - 1 || tv[i + 1].rst) begin
        compare_board($sformatf("vec%0d_end", i));
        if (mst != 0) check_ignored($sformatf("vec%0d_over", i));
      end
    end

    do_reset();
    @(negedge clk);
    drop_col = 3'd2;
    player = 1'b0;
    drop_valid = 1'b1;
    rd_row = 3'd0;
    rd_col = 3'd2;
    @(negedge clk);
    drop_valid = 1'b0;
    @(negedge clk);
    chk("abort_cell_placed", int'(rd_cell), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_status", int'(game_status), 0);
    compare_board("abort");

    @(negedge clk);
    drop_col = 3'd1;
    player = 1'b0;
    drop_valid = 1'b1;
    @(negedge clk);
    drop_valid = 1'b0;
    @(negedge clk);
    drop_col = 3'd5;
    player = 1'b1;
    drop_valid = 1'b1;
    @(negedge clk);
    drop_valid = 1'b0;
    model_drop(1, 0, m_inv, m_row);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("busy_drop_dones", dones, 1);
    compare_board("busy_drop");

    for (int g = 0; g < 25; g++) begin
      do_reset();
      n = 0;
      while (mst == 0 && n < 60) begin
        apply($sformatf("g%0d_m%0d", g, n), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), -1, 0);
        n++;
      end
      compare_board($sformatf("g%0d", g));
      if (mst != 0) check_ignored($sformatf("g%0d_over", g));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
